// File: rtl/alu_request_scheduler_if.sv
// Requester, response and ALU handshake bundle for alu_request_scheduler.
// The scheduler connects through the slave modport; the fabric/ALU side uses master.
interface alu_request_scheduler_if #(
    parameter int unsigned NUM_REQ                = 4,
    parameter int unsigned OPERAND_BUS_WIDTH      = 8,
    parameter int unsigned OPERAND_MAX_DATA_WIDTH = 32,
    parameter int unsigned RESULT_BUS_WIDTH       = 16,
    parameter int unsigned RESULT_MAX_DATA_WIDTH  = 64
);
    localparam int unsigned IdW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                        req_valid;
    logic [3*NUM_REQ-1:0]                      req_op;
    logic [OPERAND_MAX_DATA_WIDTH*NUM_REQ-1:0] req_a;
    logic [OPERAND_MAX_DATA_WIDTH*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]                        req_ready;

    logic                             rsp_valid;
    logic [IdW-1:0]                   rsp_id;
    logic [RESULT_MAX_DATA_WIDTH-1:0] rsp_data;
    logic                             rsp_err;
    logic                             rsp_ready;

    logic                         alu_operand_valid;
    logic                         alu_operand_last;
    logic [2:0]                   alu_op;
    logic [OPERAND_BUS_WIDTH-1:0] alu_a;
    logic [OPERAND_BUS_WIDTH-1:0] alu_b;
    logic                         alu_ready;
    logic                         alu_result_valid;
    logic                         alu_result_last;
    logic [RESULT_BUS_WIDTH-1:0]  alu_result;

    logic busy;

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        input  alu_ready, alu_result_valid, alu_result_last, alu_result,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
        output alu_operand_valid, alu_operand_last, alu_op, alu_a, alu_b, busy
    );

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        output alu_ready, alu_result_valid, alu_result_last, alu_result,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
        input  alu_operand_valid, alu_operand_last, alu_op, alu_a, alu_b, busy
    );
endinterface

// File: rtl/alu_request_scheduler.sv
// Round-robin scheduler sharing one beat-serial ALU between NUM_REQ requesters.
// Optional result timeout with ALU abort is enabled by defining ALU_SCHED_TIMEOUT_EN.
module alu_request_scheduler #(
    parameter int unsigned NUM_REQ                = 4,
    parameter int unsigned OPERAND_BUS_WIDTH      = 8,
    parameter int unsigned OPERAND_MAX_DATA_WIDTH = 32,
    parameter int unsigned RESULT_BUS_WIDTH       = 16,
    parameter int unsigned RESULT_MAX_DATA_WIDTH  = 64,
    parameter int unsigned TIMEOUT_CYCLES         = 64
) (
    input logic                    clk,
    input logic                    rst,
    alu_request_scheduler_if.slave bus
);
    localparam int unsigned IdW         = $clog2(NUM_REQ);
    localparam int unsigned NumOpBeats  = OPERAND_MAX_DATA_WIDTH / OPERAND_BUS_WIDTH;
    localparam int unsigned NumResBeats = RESULT_MAX_DATA_WIDTH / RESULT_BUS_WIDTH;
    localparam int unsigned OpBeatW     = (NumOpBeats > 1) ? $clog2(NumOpBeats) : 1;
    localparam int unsigned ResBeatW    = (NumResBeats > 1) ? $clog2(NumResBeats) : 1;
    localparam logic [OpBeatW-1:0]  LastOpBeat  = OpBeatW'(NumOpBeats - 1);
    localparam logic [ResBeatW-1:0] LastResBeat = ResBeatW'(NumResBeats - 1);
    localparam logic [2:0] OpAbort = 3'b111;

    if (NUM_REQ < 2 || TIMEOUT_CYCLES == 0 ||
        OPERAND_MAX_DATA_WIDTH % OPERAND_BUS_WIDTH != 0 ||
        RESULT_MAX_DATA_WIDTH % RESULT_BUS_WIDTH != 0) begin : gen_param_check
        $fatal(1, "alu_request_scheduler: unsupported parameterisation");
    end

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StCollect,
        StResp
`ifdef ALU_SCHED_TIMEOUT_EN
        , StAbort
`endif
    } state_e;

    state_e                            state_q, state_d;
    logic [IdW-1:0]                    last_grant_q, last_grant_d;
    logic [IdW-1:0]                    id_q, id_d;
    logic [2:0]                        op_q, op_d;
    logic [OPERAND_MAX_DATA_WIDTH-1:0] a_q, a_d;
    logic [OPERAND_MAX_DATA_WIDTH-1:0] b_q, b_d;
    logic [OpBeatW-1:0]                op_beat_q, op_beat_d;
    logic [ResBeatW-1:0]               res_beat_q, res_beat_d;
    logic [RESULT_MAX_DATA_WIDTH-1:0]  res_q, res_d;
    logic                              err_q, err_d;
`ifdef ALU_SCHED_TIMEOUT_EN
    localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TimerW-1:0] timer_q, timer_d;
`endif

    logic                             grant_found;
    logic [IdW-1:0]                   grant_idx;
    logic [IdW-1:0]                   cand;
    logic [2:0]                       op_sel;
    logic                             op_legal;

    logic [NUM_REQ-1:0]               req_ready_c;
    logic                             rsp_valid_c;
    logic [IdW-1:0]                   rsp_id_c;
    logic [RESULT_MAX_DATA_WIDTH-1:0] rsp_data_c;
    logic                             rsp_err_c;
    logic                             alu_valid_c;
    logic                             alu_last_c;
    logic [2:0]                       alu_op_c;
    logic [OPERAND_BUS_WIDTH-1:0]     alu_a_c;
    logic [OPERAND_BUS_WIDTH-1:0]     alu_b_c;
    logic                             busy_c;

    // First valid requester after last_grant, in modulo order.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = IdW'((32'(last_grant_q) + off) % NUM_REQ);
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
        op_sel   = bus.req_op[grant_idx*3 +: 3];
        op_legal = op_sel inside {3'b001, 3'b010, 3'b011, 3'b100};
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        op_beat_d    = op_beat_q;
        res_beat_d   = res_beat_q;
        res_d        = res_q;
        err_d        = err_q;
`ifdef ALU_SCHED_TIMEOUT_EN
        timer_d      = timer_q;
`endif
        req_ready_c  = '0;
        rsp_valid_c  = 1'b0;
        rsp_id_c     = '0;
        rsp_data_c   = '0;
        rsp_err_c    = 1'b0;
        alu_valid_c  = 1'b0;
        alu_last_c   = 1'b0;
        alu_op_c     = '0;
        alu_a_c      = '0;
        alu_b_c      = '0;
        busy_c       = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    req_ready_c[grant_idx] = 1'b1;
                    id_d         = grant_idx;
                    last_grant_d = grant_idx;
                    op_d         = op_sel;
                    a_d          = bus.req_a[grant_idx*OPERAND_MAX_DATA_WIDTH +: OPERAND_MAX_DATA_WIDTH];
                    b_d          = bus.req_b[grant_idx*OPERAND_MAX_DATA_WIDTH +: OPERAND_MAX_DATA_WIDTH];
                    res_d        = '0;
                    op_beat_d    = '0;
                    res_beat_d   = '0;
                    err_d        = !op_legal;
                    state_d      = op_legal ? StSend : StResp;
                end
            end
            StSend: begin
                alu_valid_c = bus.alu_ready;
                alu_last_c  = (op_beat_q == LastOpBeat);
                alu_op_c    = op_q;
                alu_a_c     = a_q[op_beat_q*OPERAND_BUS_WIDTH +: OPERAND_BUS_WIDTH];
                alu_b_c     = b_q[op_beat_q*OPERAND_BUS_WIDTH +: OPERAND_BUS_WIDTH];
                if (bus.alu_ready) begin
                    if (op_beat_q == LastOpBeat) begin
                        state_d = StCollect;
`ifdef ALU_SCHED_TIMEOUT_EN
                        timer_d = '0;
`endif
                    end else begin
                        op_beat_d = op_beat_q + 1'b1;
                    end
                end
            end
            StCollect: begin
                if (bus.alu_result_valid) begin
                    res_d[res_beat_q*RESULT_BUS_WIDTH +: RESULT_BUS_WIDTH] = bus.alu_result;
                    if (res_beat_q != LastResBeat) begin
                        res_beat_d = res_beat_q + 1'b1;
                    end
                    if (bus.alu_result_last) begin
                        state_d = StResp;
                    end
`ifdef ALU_SCHED_TIMEOUT_EN
                    timer_d = '0;
                // A last beat arriving on the expiry cycle is taken above, so it wins.
                end else if (timer_q == TimerW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = StAbort;
                end else begin
                    timer_d = timer_q + 1'b1;
`endif
                end
            end
            StResp: begin
                rsp_valid_c = 1'b1;
                rsp_id_c    = id_q;
                rsp_data_c  = res_q;
                rsp_err_c   = err_q;
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
`ifdef ALU_SCHED_TIMEOUT_EN
            StAbort: begin
                // Opcode 111 tells the ALU to drop whatever it was working on.
                alu_valid_c = 1'b1;
                alu_op_c    = OpAbort;
                res_d       = '0;
                err_d       = 1'b1;
                state_d     = StResp;
            end
`endif
            default: state_d = StIdle;
        endcase

        // Outputs are quiet in the reset cycle, so no grant or ALU beat escapes.
        if (rst) begin
            req_ready_c = '0;
            rsp_valid_c = 1'b0;
            rsp_id_c    = '0;
            rsp_data_c  = '0;
            rsp_err_c   = 1'b0;
            alu_valid_c = 1'b0;
            alu_last_c  = 1'b0;
            alu_op_c    = '0;
            alu_a_c     = '0;
            alu_b_c     = '0;
            busy_c      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= IdW'(NUM_REQ - 1);
            id_q         <= '0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            op_beat_q    <= '0;
            res_beat_q   <= '0;
            res_q        <= '0;
            err_q        <= 1'b0;
`ifdef ALU_SCHED_TIMEOUT_EN
            timer_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_beat_q    <= op_beat_d;
            res_beat_q   <= res_beat_d;
            res_q        <= res_d;
            err_q        <= err_d;
`ifdef ALU_SCHED_TIMEOUT_EN
            timer_q      <= timer_d;
`endif
        end
    end

    assign bus.req_ready         = req_ready_c;
    assign bus.rsp_valid         = rsp_valid_c;
    assign bus.rsp_id            = rsp_id_c;
    assign bus.rsp_data          = rsp_data_c;
    assign bus.rsp_err           = rsp_err_c;
    assign bus.alu_operand_valid = alu_valid_c;
    assign bus.alu_operand_last  = alu_last_c;
    assign bus.alu_op            = alu_op_c;
    assign bus.alu_a             = alu_a_c;
    assign bus.alu_b             = alu_b_c;
    assign bus.busy              = busy_c;
endmodule

// File: doc/alu_request_scheduler.md
# alu_request_scheduler

Shares one multi-cycle ALU between `NUM_REQ` requesters. Each requester submits a complete operation: an opcode and full-width operands. The scheduler grants requesters round-robin and serialises the operands onto the ALU's narrow operand bus. It then reassembles the ALU's result beats into one full-width word and returns that word to the granted requester with its ID. It sits between the requester fabric and the ALU.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (≥2)
- `OPERAND_BUS_WIDTH`, 8: ALU operand beat width
- `OPERAND_MAX_DATA_WIDTH`, 32: full operand width
- `RESULT_BUS_WIDTH`, 16: ALU result beat width
- `RESULT_MAX_DATA_WIDTH`, 64: full result width
- `TIMEOUT_CYCLES`, 64: result wait limit (only with the timeout macro)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; one clock; reset is synchronous and active-high
- `req_valid`  in  NUM_REQ  per-requester request
- `req_op`  in  3*NUM_REQ  opcode, slice i = requester i
- `req_a`, `req_b`  in  OPERAND_MAX_DATA_WIDTH*NUM_REQ  operands
- `req_ready`  out  NUM_REQ  one-cycle accept pulse, one-hot
- `rsp_valid`  out  1  response available
- `rsp_id`  out  $clog2(NUM_REQ)  granted requester
- `rsp_data`  out  RESULT_MAX_DATA_WIDTH  reassembled result
- `rsp_err`  out  1  illegal opcode or timeout
- `rsp_ready`  in  1  response consumed
- `alu_operand_valid`, `alu_operand_last`  out  1  ALU operand handshake
- `alu_op`  out  3  ALU opcode
- `alu_a`, `alu_b`  out  OPERAND_BUS_WIDTH  operand beat
- `alu_ready`  in  1  ALU can take an operand beat
- `alu_result_valid`, `alu_result_last`  in  1  ALU result handshake
- `alu_result`  in  RESULT_BUS_WIDTH  result beat
- `busy`  out  1  high in every state except IDLE

## Operation
- States are IDLE, SEND, COLLECT, RESP and, with the timeout macro, ABORT.
- **IDLE, grant:**
  - If any `req_valid` is set, pulse `req_ready[g]` for the first valid requester after `last_grant` in modulo order.
  - Latch op, a, b and g. Clear the result register. Set `last_grant` to g.
  - After reset, `last_grant` is NUM_REQ-1, so requester 0 wins first.
- **Opcode check:** legal opcodes are 001, 010, 011 and 100. Any other opcode goes straight to RESP with `rsp_data`=0 and `rsp_err`=1. The ALU is not touched.
- **SEND:**
  - Issues N = OPERAND_MAX_DATA_WIDTH/OPERAND_BUS_WIDTH beats, always all N, including zero upper slices.
  - `alu_operand_valid` is asserted only while `alu_ready`=1; beat k then carries operand slice k.
  - `alu_op` holds the latched opcode on every beat. `alu_operand_last` is set on beat N-1.
  - After beat N-1 is accepted, go to COLLECT.
- **COLLECT:**
  - Each cycle with `alu_result_valid` writes `alu_result` into result slice k, then increments k.
  - k saturates at RESULT_MAX_DATA_WIDTH/RESULT_BUS_WIDTH-1. Slices never written stay 0.
  - When `alu_result_last` arrives, go to RESP.
  - `alu_result_valid` seen in any other state is ignored.
- **RESP:** `rsp_valid`=1 with `rsp_id`, `rsp_data` and `rsp_err` held stable until `rsp_ready`. Then return to IDLE.
- Addition results are zero-extended; multiplication gives the full 64-bit product.
- **Reset values:** all outputs 0 and state IDLE. Reset mid-operation abandons the transfer with no response and no ALU beat. Resetting the ALU is the integrator's job.

## Timing
- Grant pulse at cycle T; the first ALU beat is at T+1 at the earliest. With `alu_ready` held high, the last beat is at T+N.
- RESP is entered, with `rsp_valid`=1, the cycle after the `alu_result_last` beat is captured.
- An illegal opcode gives `rsp_valid` at T+1.
- The next grant is no earlier than the cycle after the `rsp_valid`&&`rsp_ready` handshake, so at most one operation is in flight.
- `req_valid` dropping after the grant has no effect. Requests are not queued.

## Configuration
- Macro: `ALU_SCHED_TIMEOUT_EN`.
- **Defined:**
  - COLLECT counts cycles since entry or since the last result beat.
  - If the count reaches TIMEOUT_CYCLES, go to ABORT. ABORT drives one cycle of `alu_operand_valid`=1 with `alu_op`=3'b111, regardless of `alu_ready`, to reset the ALU.
  - Then go to RESP with `rsp_data`=0 and `rsp_err`=1.
  - If `alu_result_last` and expiry fall in the same cycle, the result wins.
- **Undefined:** COLLECT waits indefinitely, and ABORT and the counter are absent.

## Test plan
- Requester 1 sends ADD a=0x0000_00FF, b=0x0000_0001 → `req_ready`=0b0010, 4 operand beats with the last flagged → `rsp_id`=1, `rsp_data`=0x100, `rsp_err`=0.
- Requester 0 sends MUL a=b=0xFFFF_FFFF → `rsp_data`=0xFFFF_FFFE_0000_0001.
- All four requesters hold `req_valid` with XOR ops → grants in order 0,1,2,3,0, each next grant after the prior `rsp_ready`.
- Opcode 3'b110 from requester 2 → `rsp_valid` at T+1 with `rsp_err`=1, `rsp_data`=0, and no `alu_operand_valid`.
- `alu_ready` low for 5 cycles mid-SEND, then `rsp_ready` low for 3 cycles → no beat lost or repeated; response held stable.
- With `ALU_SCHED_TIMEOUT_EN`, the ALU gives no result for 64 cycles → one beat with op 111, then `rsp_err`=1. Separately, `rst` asserted mid-COLLECT → all outputs 0, and requester 0 is granted first afterwards.
